// File: rtl/ssit_trainer_if.sv
// Violation report channel into the SSIT trainer.
// Producer holds valid and both PCs stable until ready is seen at an edge.
interface ssit_trainer_if #(
    parameter int IDX_W = 10
);
    logic             viol_valid_in;
    logic             viol_ready_out;
    logic [IDX_W-1:0] viol_load_pc_in;
    logic [IDX_W-1:0] viol_store_pc_in;

    modport master (
        output viol_valid_in,
        output viol_load_pc_in,
        output viol_store_pc_in,
        input  viol_ready_out
    );

    modport slave (
        input  viol_valid_in,
        input  viol_load_pc_in,
        input  viol_store_pc_in,
        output viol_ready_out
    );
endinterface

// File: rtl/ssit_trainer.sv
// Store Set ID Table: 4-wide registered lookup, violation-driven merge
// training and a periodic whole-table invalidate.
module ssit_trainer #(
    parameter int IDX_W          = 10,
    parameter int SSID_W         = 7,
    parameter int CLEAR_INTERVAL = 65536
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  pc0_in,
    input  logic [IDX_W-1:0]  pc1_in,
    input  logic [IDX_W-1:0]  pc2_in,
    input  logic [IDX_W-1:0]  pc3_in,
    input  logic              valid0_in,
    input  logic              valid1_in,
    input  logic              valid2_in,
    input  logic              valid3_in,
    output logic [SSID_W-1:0] ssid0_out,
    output logic [SSID_W-1:0] ssid1_out,
    output logic [SSID_W-1:0] ssid2_out,
    output logic [SSID_W-1:0] ssid3_out,
    output logic              valid0_out,
    output logic              valid1_out,
    output logic              valid2_out,
    output logic              valid3_out,
    ssit_trainer_if.slave     viol,
    output logic              busy_out
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = (CLEAR_INTERVAL > 2) ? $clog2(CLEAR_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_INTERVAL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_CLR  = 2'd3;

    logic [1:0]        state_f;
    logic [SSID_W-1:0] ssid_mem [DEPTH];
    logic [DEPTH-1:0]  valid_f;
    logic [SSID_W-1:0] alloc_f;
    logic [CNT_W-1:0]  clr_cnt_f;
    logic              clr_pend_f;
    logic [IDX_W-1:0]  ld_pc_f;
    logic [IDX_W-1:0]  st_pc_f;
    logic              vl_f;
    logic              vs_f;
    logic [SSID_W-1:0] sl_f;
    logic [SSID_W-1:0] ss_f;

    logic [IDX_W-1:0]  pc [4];
    logic [3:0]        req;
    logic [SSID_W-1:0] ssid_q [4];
    logic [3:0]        vld_q;

    logic [SSID_W-1:0] wr_ld;
    logic [SSID_W-1:0] wr_st;
    logic              alloc_inc;
    logic              clr_hit;

    assign pc[0] = pc0_in;
    assign pc[1] = pc1_in;
    assign pc[2] = pc2_in;
    assign pc[3] = pc3_in;
    assign req   = {valid3_in, valid2_in, valid1_in, valid0_in};

    assign ssid0_out  = ssid_q[0];
    assign ssid1_out  = ssid_q[1];
    assign ssid2_out  = ssid_q[2];
    assign ssid3_out  = ssid_q[3];
    assign valid0_out = vld_q[0];
    assign valid1_out = vld_q[1];
    assign valid2_out = vld_q[2];
    assign valid3_out = vld_q[3];

    assign viol.viol_ready_out = (state_f == S_IDLE) & ~clr_pend_f;
    assign busy_out            = (state_f != S_IDLE);
    assign clr_hit             = (clr_cnt_f == CNT_LAST);

    // Lookups read the pre-edge table, so same-edge writes are not seen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) ssid_q[i] <= '0;
            vld_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ssid_q[i] <= ssid_mem[pc[i]];
                vld_q[i]  <= valid_f[pc[i]] & req[i];
            end
        end
    end

    // Merge rule; equal PCs always land in the 00 or 11 arm.
    always_comb begin
        wr_ld     = sl_f;
        wr_st     = sl_f;
        alloc_inc = 1'b0;
        unique case ({vl_f, vs_f})
            2'b00: begin
                wr_ld     = alloc_f;
                wr_st     = alloc_f;
                alloc_inc = 1'b1;
            end
            2'b10: begin
                wr_ld = sl_f;
                wr_st = sl_f;
            end
            2'b01: begin
                wr_ld = ss_f;
                wr_st = ss_f;
            end
            2'b11: begin
                wr_ld = (sl_f < ss_f) ? sl_f : ss_f;
                wr_st = (sl_f < ss_f) ? sl_f : ss_f;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (state_f == S_WR) begin
            ssid_mem[ld_pc_f] <= wr_ld;
            ssid_mem[st_pc_f] <= wr_st;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_f    <= S_IDLE;
            valid_f    <= '0;
            alloc_f    <= '0;
            clr_cnt_f  <= '0;
            clr_pend_f <= 1'b0;
            ld_pc_f    <= '0;
            st_pc_f    <= '0;
            vl_f       <= 1'b0;
            vs_f       <= 1'b0;
            sl_f       <= '0;
            ss_f       <= '0;
        end else begin
            // A new pending clear wins over the one being retired.
            if (clr_hit) begin
                clr_cnt_f  <= '0;
                clr_pend_f <= 1'b1;
            end else begin
                clr_cnt_f <= clr_cnt_f + CNT_W'(1);
                if (state_f == S_CLR) clr_pend_f <= 1'b0;
            end

            case (state_f)
                S_IDLE: begin
                    if (clr_pend_f) begin
                        state_f <= S_CLR;
                    end else if (viol.viol_valid_in) begin
                        ld_pc_f <= viol.viol_load_pc_in;
                        st_pc_f <= viol.viol_store_pc_in;
                        state_f <= S_RD;
                    end
                end
                S_RD: begin
                    vl_f    <= valid_f[ld_pc_f];
                    vs_f    <= valid_f[st_pc_f];
                    sl_f    <= ssid_mem[ld_pc_f];
                    ss_f    <= ssid_mem[st_pc_f];
                    state_f <= S_WR;
                end
                S_WR: begin
                    valid_f[ld_pc_f] <= 1'b1;
                    valid_f[st_pc_f] <= 1'b1;
                    if (alloc_inc) alloc_f <= alloc_f + SSID_W'(1);
                    state_f <= clr_pend_f ? S_CLR : S_IDLE;
                end
                S_CLR: begin
                    valid_f <= '0;
                    state_f <= S_IDLE;
                end
                default: state_f <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssit_trainer.sv
// Randomised bench for ssit_trainer against a table-level reference model.
// The model tracks entries, allocation and clear timing by edge numbers.
module tb_ssit_trainer;

    localparam int IDX_W = 10;
    localparam int SSID_W = 7;
    localparam int CI = 32;
    localparam int DEPTH = 1 << IDX_W;

    logic clock;
    logic reset_n;
    logic [3:0][IDX_W-1:0] pci;
    logic [3:0] vi;
    logic [3:0][SSID_W-1:0] so;
    logic [3:0] vo;
    logic busy;

    ssit_trainer_if #(.IDX_W(IDX_W)) vif ();

    ssit_trainer #(
        .IDX_W(IDX_W),
        .SSID_W(SSID_W),
        .CLEAR_INTERVAL(CI)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .pc0_in(pci[0]),
        .pc1_in(pci[1]),
        .pc2_in(pci[2]),
        .pc3_in(pci[3]),
        .valid0_in(vi[0]),
        .valid1_in(vi[1]),
        .valid2_in(vi[2]),
        .valid3_in(vi[3]),
        .ssid0_out(so[0]),
        .ssid1_out(so[1]),
        .ssid2_out(so[2]),
        .ssid3_out(so[3]),
        .valid0_out(vo[0]),
        .valid1_out(vo[1]),
        .valid2_out(vo[2]),
        .valid3_out(vo[3]),
        .viol(vif),
        .busy_out(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model state
    bit tv [DEPTH];
    bit tw [DEPTH];
    bit [SSID_W-1:0] ts [DEPTH];
    bit [SSID_W-1:0] alloc;
    bit pend;
    int cnt;
    int e;
    int acc_e;
    int clr_e;
    bit m_acc;
    bit [IDX_W-1:0] m_ld;
    bit [IDX_W-1:0] m_st;
    bit ev [4];
    bit ek [4];
    bit [SSID_W-1:0] es [4];

    // Edge n is a training or clear edge (the trainer is not idle before it).
    function automatic bit busy_at(input int n);
        return (n == acc_e + 1) || (n == acc_e + 2) || (n == clr_e);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) tv[i] = 1'b0;
        alloc = '0;
        pend = 1'b0;
        cnt = 0;
        e = 0;
        acc_e = -100;
        clr_e = -100;
        m_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = 1'b0;
            ek[i] = 1'b1;
            es[i] = '0;
        end
    endtask

    task automatic merge();
        bit vl, vs;
        bit [SSID_W-1:0] sl, ss, m;
        vl = tv[m_ld];
        vs = tv[m_st];
        sl = ts[m_ld];
        ss = ts[m_st];
        if (!vl && !vs) begin
            ts[m_ld] = alloc;
            ts[m_st] = alloc;
            alloc = alloc + 1'b1;
        end else if (vl && !vs) begin
            ts[m_st] = sl;
        end else if (!vl && vs) begin
            ts[m_ld] = ss;
        end else begin
            m = (sl < ss) ? sl : ss;
            ts[m_ld] = m;
            ts[m_st] = m;
        end
        tv[m_ld] = 1'b1;
        tv[m_st] = 1'b1;
        tw[m_ld] = 1'b1;
        tw[m_st] = 1'b1;
    endtask

    task automatic model_step();
        int n;
        bit idle, wipe;
        n = e + 1;
        idle = !busy_at(n);
        for (int i = 0; i < 4; i++) begin
            ev[i] = vi[i] && tv[pci[i]];
            es[i] = ts[pci[i]];
            ek[i] = tw[pci[i]];
        end
        m_acc = vif.viol_valid_in && idle && !pend;
        wipe = (n == clr_e);
        if (n == acc_e + 2) begin
            merge();
            if (pend) clr_e = n + 1;
        end
        if (wipe) for (int i = 0; i < DEPTH; i++) tv[i] = 1'b0;
        if (idle && pend) clr_e = n + 1;
        if (m_acc) begin
            acc_e = n;
            m_ld = vif.viol_load_pc_in;
            m_st = vif.viol_store_pc_in;
        end
        if (cnt == CI - 1) begin
            cnt = 0;
            pend = 1'b1;
        end else begin
            cnt++;
            if (wipe) pend = 1'b0;
        end
        e = n;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vout%0d", i), 32'(vo[i]), 32'(ev[i]));
            if (ek[i]) chk($sformatf("ssid%0d", i), 32'(so[i]), 32'(es[i]));
        end
        chk("ready", 32'(vif.viol_ready_out), 32'(!busy_at(e + 1) && !pend));
        chk("busy", 32'(busy), 32'(busy_at(e + 1)));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic look(input int a, input int b, input int c, input int d);
        pci[0] = IDX_W'(a);
        pci[1] = IDX_W'(b);
        pci[2] = IDX_W'(c);
        pci[3] = IDX_W'(d);
        vi = 4'hF;
        tick();
        vi = 4'h0;
    endtask

    task automatic wait_acc();
        int k;
        k = 0;
        m_acc = 1'b0;
        while (!m_acc && k < 100) begin
            tick();
            k++;
        end
        if (!m_acc) chk("accept_timeout", 32'(m_acc), 32'd1);
        vif.viol_valid_in = 1'b0;
    endtask

    task automatic send_viol(input int ld, input int st);
        int k;
        vif.viol_load_pc_in = IDX_W'(ld);
        vif.viol_store_pc_in = IDX_W'(st);
        vif.viol_valid_in = 1'b1;
        wait_acc();
        k = 0;
        while (busy_at(e + 1) && k < 100) begin
            tick();
            k++;
        end
        if (busy_at(e + 1)) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int k;
        reset_n = 1'b1;
        pci = '0;
        vi = '0;
        vif.viol_valid_in = 1'b0;
        vif.viol_load_pc_in = '0;
        vif.viol_store_pc_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tw[i] = 1'b0;
            ts[i] = '0;
        end
        model_reset();
        #2;
        do_reset();

        look(5, 0, 0, 0);
        chk("t1_v5", 32'(vo[0]), 32'd0);

        send_viol(10, 20);
        look(10, 20, 0, 0);
        chk("t2_v10", 32'(vo[0]), 32'd1);
        chk("t2_s10", 32'(so[0]), 32'd0);
        chk("t2_s20", 32'(so[1]), 32'd0);

        send_viol(30, 20);
        send_viol(40, 50);
        look(30, 40, 50, 20);
        chk("t3_s30", 32'(so[0]), 32'd0);
        chk("t3_s40", 32'(so[1]), 32'd1);
        chk("t3_s50", 32'(so[2]), 32'd1);

        send_viol(40, 10);
        look(40, 10, 0, 0);
        chk("t4_s40", 32'(so[0]), 32'd0);
        chk("t4_s10", 32'(so[1]), 32'd0);

        k = 0;
        while (!pend && k < 200) begin
            tick();
            k++;
        end
        chk("t5_pend_seen", 32'(pend), 32'd1);
        chk("t5_rdy", 32'(vif.viol_ready_out), 32'd0);
        send_viol(60, 70);
        look(10, 60, 70, 20);
        chk("t5_v10", 32'(vo[0]), 32'd0);
        chk("t5_s60", 32'(so[1]), 32'd2);
        chk("t5_v70", 32'(vo[2]), 32'd1);

        vif.viol_load_pc_in = IDX_W'(100);
        vif.viol_store_pc_in = IDX_W'(200);
        vif.viol_valid_in = 1'b1;
        wait_acc();
        tick();
        chk("t6_busy_wr", 32'(busy), 32'd1);
        do_reset();
        chk("t6_rst_v", 32'(vo), 32'd0);
        chk("t6_rst_rdy", 32'(vif.viol_ready_out), 32'd1);
        look(10, 100, 200, 60);
        chk("t6_v", 32'(vo), 32'd0);
        send_viol(300, 301);
        look(300, 301, 0, 0);
        chk("t6_alloc0", 32'(so[0]), 32'd0);
        chk("t6_v300", 32'(vo[0]), 32'd1);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                pci[i] = ($urandom_range(0, 7) == 0) ?
                         IDX_W'($urandom) : IDX_W'($urandom_range(0, 31));
            end
            vi = 4'($urandom);
            if (!vif.viol_valid_in && $urandom_range(0, 3) == 0) begin
                vif.viol_load_pc_in = IDX_W'($urandom_range(0, 31));
                vif.viol_store_pc_in = ($urandom_range(0, 7) == 0) ?
                    vif.viol_load_pc_in : IDX_W'($urandom_range(0, 31));
                vif.viol_valid_in = 1'b1;
            end
            tick();
            if (m_acc) vif.viol_valid_in = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
